// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl
// Latches GPIO rising/falling edge pulses into pending registers under
// per-pin enables and drives one registered interrupt request to the CPU.
// The reported source is the highest-priority active pending bit.
//
// Optional feature macro: GPIO_IRQC_CLAIM_EN maps the CLAIM register at 0x14.
// Its read returns the current winner and clears that pending bit.
//
// Ports:
//   PCLK, PRESET             clock, asynchronous active-high reset
//   PADDR/PWRITE/PWDATA/     APB slave, zero wait states; PADDR[4:2] picks
//   PSTRB/PSEL/PENABLE       the register
//   PRDATA/PREADY/PSLVERR    APB response
//   irqsx_gpio_pedge/nedge   one-cycle edge pulses, one bit per pin
//   gpio_irq, gpio_irq_id    registered request and source {falling, pin}
module gpio_irq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [STRB_W-1:0] PSTRB,
  input  logic              PSEL,
  input  logic              PENABLE,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [15:0]       irqsx_gpio_pedge,
  input  logic [15:0]       irqsx_gpio_nedge,
  output logic              gpio_irq,
  output logic [4:0]        gpio_irq_id
);

  localparam logic [2:0] SEL_PEDGE_EN = 3'd0;
  localparam logic [2:0] SEL_NEDGE_EN = 3'd1;
  localparam logic [2:0] SEL_PEND_P   = 3'd2;
  localparam logic [2:0] SEL_PEND_N   = 3'd3;
  localparam logic [2:0] SEL_STATUS   = 3'd4;
  localparam logic [2:0] SEL_CLAIM    = 3'd5;

  logic [15:0] pedge_en_q, pedge_en_d;
  logic [15:0] nedge_en_q, nedge_en_d;
  logic [15:0] pend_p_q, pend_p_d;
  logic [15:0] pend_n_q, pend_n_d;
  logic        irq_q, irq_d;
  logic [4:0]  irq_id_q, irq_id_d;

  logic [2:0]  reg_sel;
  logic        wr_acc;
  logic        rd_acc;
  logic        mapped;
  logic [15:0] wmask;
  logic [15:0] wbits;
  logic [15:0] act_p, act_n;
  logic        arb_valid;
  logic [4:0]  arb_id;
  logic [15:0] claim_clr_p, claim_clr_n;
  logic [15:0] clr_p, clr_n;
  logic        unused_ok;

  assign reg_sel = PADDR[4:2];
  assign wr_acc  = PSEL & PENABLE & PWRITE;
  assign rd_acc  = PSEL & PENABLE & ~PWRITE;
  assign wmask   = {{8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign wbits   = PWDATA[15:0] & wmask;

  assign unused_ok = ^{PADDR[ADDR_W-1:5], PADDR[1:0], PSTRB[STRB_W-1:2],
                       PWDATA[DATA_W-1:16]};

  assign act_p = pend_p_q & pedge_en_q;
  assign act_n = pend_n_q & nedge_en_q;

  // Scan from lowest priority upwards so the last hit (lowest pin) wins;
  // within a pin the rising check comes last so it overrides falling.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (act_n[i]) begin
        arb_valid = 1'b1;
        arb_id    = {1'b1, 4'(i)};
      end
      if (act_p[i]) begin
        arb_valid = 1'b1;
        arb_id    = {1'b0, 4'(i)};
      end
    end
  end

`ifdef GPIO_IRQC_CLAIM_EN
  logic claim_hit;
  assign claim_hit   = rd_acc & (reg_sel == SEL_CLAIM) & arb_valid;
  assign claim_clr_p = (claim_hit & ~arb_id[4]) ? (16'h0001 << arb_id[3:0]) : 16'h0000;
  assign claim_clr_n = (claim_hit &  arb_id[4]) ? (16'h0001 << arb_id[3:0]) : 16'h0000;
  assign mapped      = (reg_sel <= SEL_CLAIM);
`else
  assign claim_clr_p = 16'h0000;
  assign claim_clr_n = 16'h0000;
  assign mapped      = (reg_sel <= SEL_STATUS);
`endif

  always_comb begin
    pedge_en_d = pedge_en_q;
    nedge_en_d = nedge_en_q;
    clr_p      = claim_clr_p;
    clr_n      = claim_clr_n;
    if (wr_acc) begin
      case (reg_sel)
        SEL_PEDGE_EN: pedge_en_d = (pedge_en_q & ~wmask) | wbits;
        SEL_NEDGE_EN: nedge_en_d = (nedge_en_q & ~wmask) | wbits;
        SEL_PEND_P:   clr_p      = clr_p | wbits;
        SEL_PEND_N:   clr_n      = clr_n | wbits;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a same-cycle set survives.
    pend_p_d = (pend_p_q & ~clr_p) | (irqsx_gpio_pedge & pedge_en_q);
    pend_n_d = (pend_n_q & ~clr_n) | (irqsx_gpio_nedge & nedge_en_q);
    irq_d    = arb_valid;
    irq_id_d = arb_id;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pedge_en_q <= 16'h0000;
      nedge_en_q <= 16'h0000;
      pend_p_q   <= 16'h0000;
      pend_n_q   <= 16'h0000;
      irq_q      <= 1'b0;
      irq_id_q   <= 5'd0;
    end else begin
      pedge_en_q <= pedge_en_d;
      nedge_en_q <= nedge_en_d;
      pend_p_q   <= pend_p_d;
      pend_n_q   <= pend_n_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (reg_sel)
        SEL_PEDGE_EN: PRDATA[15:0] = pedge_en_q;
        SEL_NEDGE_EN: PRDATA[15:0] = nedge_en_q;
        SEL_PEND_P:   PRDATA[15:0] = pend_p_q;
        SEL_PEND_N:   PRDATA[15:0] = pend_n_q;
        SEL_STATUS: begin
          PRDATA[31]  = irq_q;
          PRDATA[4:0] = irq_id_q;
        end
`ifdef GPIO_IRQC_CLAIM_EN
        SEL_CLAIM: begin
          PRDATA[31]  = arb_valid;
          PRDATA[4:0] = arb_id;
        end
`endif
        default: ;
      endcase
    end
  end

  assign PREADY      = 1'b1;
  assign PSLVERR     = PSEL & PENABLE & ~mapped;
  assign gpio_irq    = irq_q;
  assign gpio_irq_id = irq_id_q;

endmodule
